shift_exec_stage: RTL and testbench

- Execute-stage wrapper around the combinational `shifter` for shll/shrl/shra and their variable forms (shllv/shrlv/shrav).
- Accepts decoded shift micro-ops from decode/operand-read through a valid/ready handshake.
- Selects the shift amount (immediate or register), drives `shifter`, and registers the result with its destination index toward writeback.
- A 2-entry skid buffer keeps `in_ready` purely registered.

---
 rtl/shift_exec_stage.sv | 181 ++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: execute-stage wrapper around the combinational shifter.
// Selects immediate or register shift amount, flags the result, and holds it
// in a main register backed by a skid register so in_ready is a flop output.
// Optional macro SHIFT_EXEC_STATS_EN adds stat_ops / stat_stalls counters.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and out_* hold steady while
// out_valid=1 and out_ready=0.

module shifter #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [4:0]        sh_amt,
  output logic [DATA_W-1:0] y
);

  // Pure combinational shift; unknown opcodes produce zero.
  always_comb begin
    y = '0;
    case (op)
      3'b011:  y = a << sh_amt;
      3'b100:  y = a >> sh_amt;
      3'b101:  y = $signed(a) >>> sh_amt;
      default: y = '0;
    endcase
  end

endmodule

module shift_exec_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_var,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [4:0]        in_shamt_imm,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_zero,
  output logic              out_sign,
  output logic              out_illegal
`ifdef SHIFT_EXEC_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_stalls
`endif
);

  typedef struct packed {
    logic              illegal;
    logic              zero;
    logic              sign;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
  } entry_t;

  logic [4:0]        sh_amt;
  logic [DATA_W-1:0] shift_y;
  logic              op_legal;
  logic              accept;
  logic              drain;
  logic              unused_rt_hi;
  entry_t            new_entry;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;

  // Only the low five bits of the register operand form the amount.
  assign sh_amt       = in_var ? in_rt_val[4:0] : in_shamt_imm;
  assign unused_rt_hi = ^in_rt_val[DATA_W-1:5];

  shifter #(.DATA_W(DATA_W)) u_shifter (
    .op     (in_op),
    .a      (in_rs_val),
    .sh_amt (sh_amt),
    .y      (shift_y)
  );

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  // Build the entry to be stored: flags come from the (possibly forced) result.
  always_comb begin
    op_legal          = (in_op == 3'b011) || (in_op == 3'b100) || (in_op == 3'b101);
    new_entry         = '0;
    new_entry.illegal = ~op_legal;
    new_entry.rd      = in_rd;
    new_entry.result  = op_legal ? shift_y : '0;
    new_entry.zero    = (new_entry.result == '0);
    new_entry.sign    = new_entry.result[DATA_W-1];
  end

  // Main/skid occupancy: new ops go to main when it frees up this edge,
  // otherwise into skid; skid refills main once main drains.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q && !drain) begin
      if (accept) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end else begin
      main_valid_d = accept;
      if (accept) main_d = new_entry;
    end
  end

  // State registers; entries are lost immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_result  = main_q.result;
  assign out_rd      = main_q.rd;
  assign out_zero    = main_q.zero;
  assign out_sign    = main_q.sign;
  assign out_illegal = main_q.illegal;

`ifdef SHIFT_EXEC_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Free-running wrap-around counters; flush does not touch them.
  always_comb begin
    stat_ops_d    = stat_ops_q + {31'd0, accept};
    stat_stalls_d = stat_stalls_q + {31'd0, (in_valid & ~in_ready)};
  end

  // Counter registers, cleared by reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q    <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_ops_q    <= stat_ops_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_ops    = stat_ops_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Testbench for shift_exec_stage: randomized and directed micro-ops, an
// arithmetic reference model feeding an expected queue, and a negedge
// monitor that pops and compares on every output transfer.
module tb_shift_exec_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EW     = 3 + REG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_op = 3'b011;
  logic              in_var = 1'b0;
  logic [DATA_W-1:0] in_rs_val = '0;
  logic [DATA_W-1:0] in_rt_val = '0;
  logic [4:0]        in_shamt_imm = '0;
  logic [REG_W-1:0]  in_rd = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_zero;
  logic              out_sign;
  logic              out_illegal;
`ifdef SHIFT_EXEC_STATS_EN
  logic [31:0]       stat_ops;
  logic [31:0]       stat_stalls;
  int unsigned       exp_ops = 0;
  int unsigned       exp_stalls = 0;
`endif

  shift_exec_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_var       (in_var),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_shamt_imm (in_shamt_imm),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_zero     (out_zero),
    .out_sign     (out_sign),
    .out_illegal  (out_illegal)
`ifdef SHIFT_EXEC_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_stalls  (stat_stalls)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic          rand_ready = 1'b0;
  logic          hold_prev = 1'b0;
  logic [EW-1:0] held_val;

  function automatic logic [EW-1:0] dut_entry();
    return {out_illegal, out_zero, out_sign, out_rd, out_result};
  endfunction

  // Reference model: shifts expressed as multiply/divide by powers of two.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic v,
                                          input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [4:0] imm, input logic [REG_W-1:0] rd);
    longint unsigned p;
    logic [31:0] r;
    logic ill;
    int amt;
    amt = v ? int'(rt % 32) : int'(imm);
    p   = 64'd1 << amt;
    ill = 1'b0;
    r   = '0;
    if (op == 3'd3) r = 32'((64'(rs) * p) % 64'h1_0000_0000);
    else if (op == 3'd4) r = 32'(64'(rs) / p);
    else if (op == 3'd5) begin
      r = 32'(64'(rs) / p);
      if (rs[31]) r = r | ~(32'(64'hFFFF_FFFF / p));
    end else ill = 1'b1;
    return {ill, (r == 32'd0), r[31], rd, r};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [2:0] op, input logic v, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] imm, input logic [REG_W-1:0] rd);
    int  budget;
    logic acc;
    in_valid = 1'b1; in_op = op; in_var = v; in_rs_val = rs;
    in_rt_val = rt; in_shamt_imm = imm; in_rd = rd;
    budget = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(model(op, v, rs, rt, imm, rd));
      end
      @(posedge clk); #1;
      budget++;
      if (!acc && budget > 200) begin
        errors++; checks++;
        $display("FAIL send_timeout got=in_ready_low exp=accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [2:0] op;
    if ($urandom_range(0, 7) == 0) op = 3'(($urandom_range(0, 4) + 6) % 8);
    else op = 3'($urandom_range(3, 5));
    send(op, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
         REG_W'($urandom_range(0, 31)));
  endtask

  // ---------------- monitor ----------------
  // Pops on every transfer and checks hold-stability while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef SHIFT_EXEC_STATS_EN
      if (in_valid && in_ready) exp_ops++;
      if (in_valid && !in_ready) exp_stalls++;
`endif
      if (hold_prev && out_valid) check("hold_stable", 64'(dut_entry()), 64'(held_val));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 64'(dut_entry()), 64'(0));
        else check("out_entry", 64'(dut_entry()), 64'(exp_q.pop_front()));
      end
      hold_prev = out_valid && !out_ready;
      held_val  = dut_entry();
    end
  end

  // Random writeback backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_illegal", 64'(out_illegal), 64'(0));
    check("reset_result", 64'(out_result), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SLL immediate, single-cycle latency
    send(3'b011, 1'b0, 32'hFFFF_FFCA, 32'h0, 5'd5, 5'd7);
    check("sll_valid", 64'(out_valid), 64'(1));
    check("sll_result", 64'(out_result), 64'h0000_0000_FFFF_F940);
    check("sll_rd", 64'(out_rd), 64'(7));
    check("sll_sign", 64'(out_sign), 64'(1));
    check("sll_zero", 64'(out_zero), 64'(0));

    // Back-to-back SRL / SRA with register amount
    send(3'b100, 1'b1, 32'hFFFF_FFCA, 32'h0000_0025, 5'd0, 5'd1);
    check("srl_result", 64'(out_result), 64'h07FF_FFFE);
    send(3'b101, 1'b1, 32'hFFFF_FFCA, 32'h0000_0025, 5'd0, 5'd2);
    check("sra_result", 64'(out_result), 64'hFFFF_FFFE);
    check("b2b_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk); #1;

    // Backpressure: two held, third waits, then all emerge in order
    out_ready = 1'b0;
    fork
      begin
        send(3'b011, 1'b0, 32'h1, 32'h0, 5'd1, 5'd3);
        send(3'b100, 1'b0, 32'h8000_0000, 32'h0, 5'd4, 5'd4);
        send(3'b101, 1'b0, 32'h8000_0000, 32'h0, 5'd4, 5'd5);
      end
      begin
        repeat (6) @(posedge clk); #1;
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
      end
    join
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin @(posedge clk); #1; budget++; end
    check("bp_drained", 64'(exp_q.size()), 64'(0));
`ifdef SHIFT_EXEC_STATS_EN
    check("bp_stat_ops", 64'(stat_ops), 64'(exp_ops));
    check("bp_stat_stalls", 64'(stat_stalls), 64'(exp_stalls));
`endif

    // Illegal op followed by a legal one
    send(3'b111, 1'b0, 32'h0000_1234, 32'h0, 5'd2, 5'd9);
    check("ill_flag", 64'(out_illegal), 64'(1));
    check("ill_result", 64'(out_result), 64'(0));
    check("ill_zero", 64'(out_zero), 64'(1));
    send(3'b011, 1'b0, 32'h0000_1234, 32'h0, 5'd2, 5'd10);
    check("legal_after_ill", 64'(out_illegal), 64'(0));
    repeat (2) @(posedge clk); #1;

    // Flush with both slots full and a pending op
    out_ready = 1'b0;
    send(3'b011, 1'b0, 32'hAAAA_0001, 32'h0, 5'd3, 5'd11);
    send(3'b100, 1'b0, 32'hAAAA_0002, 32'h0, 5'd3, 5'd12);
    check("pre_flush_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b1; in_op = 3'b101; in_rs_val = 32'hDEAD_BEEF; in_rd = 5'd13;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("post_flush_quiet", 64'(out_valid), 64'(0));

    // Async reset pulse between edges with entries pending
    out_ready = 1'b0;
    send(3'b011, 1'b0, 32'h5, 32'h0, 5'd1, 5'd14);
    send(3'b011, 1'b0, 32'h6, 32'h0, 5'd1, 5'd15);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    hold_prev = 1'b0;
`ifdef SHIFT_EXEC_STATS_EN
    exp_ops = 0; exp_stalls = 0;
`endif
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (3) @(posedge clk); #1;
    check("rst_no_stale", 64'(out_valid), 64'(0));

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_rand();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin @(posedge clk); #1; budget++; end
    check("final_drained", 64'(exp_q.size()), 64'(0));
    check("final_in_ready", 64'(in_ready), 64'(1));
`ifdef SHIFT_EXEC_STATS_EN
    @(negedge clk);
    check("final_stat_ops", 64'(stat_ops), 64'(exp_ops));
    check("final_stat_stalls", 64'(stat_stalls), 64'(exp_stalls));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
